// File: rtl/spec_reg_stack_if.sv
// Bus between the control unit and the special-purpose status register:
// ALU/shifter flag inputs, operation select, and the registered status view.
interface spec_reg_stack_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             enable;
  logic [3:0]       update_mode;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             bs_negative;
  logic             bs_zero;
  logic             bs_carry;
  logic [4:0]       wr_data;

  logic             negative_flag;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             mode_flag;
  logic             is_bios;
  logic [LVL_W-1:0] stack_level;
  logic             stack_overflow;
  logic             stack_underflow;

  modport master (
    output enable, update_mode,
    output alu_negative, alu_zero, alu_carry, alu_overflow,
    output bs_negative, bs_zero, bs_carry, wr_data,
    input  negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag,
    input  is_bios, stack_level, stack_overflow, stack_underflow
  );

  modport slave (
    input  enable, update_mode,
    input  alu_negative, alu_zero, alu_carry, alu_overflow,
    input  bs_negative, bs_zero, bs_carry, wr_data,
    output negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag,
    output is_bios, stack_level, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/spec_reg_stack.sv
// Status register (NZCV, mode, is_bios) with a LIFO save stack for exception
// entry/return, an explicit load path, and sticky stack-error flags.
module spec_reg_stack #(
  parameter int unsigned DEPTH      = 4,
  parameter logic        RESET_MODE = 1'b0
) (
  input logic             clock,
  input logic             reset,
  spec_reg_stack_if.slave bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
    logic m;
  } nzcvm_t;

  typedef enum logic [3:0] {
    OP_HOLD    = 4'd0,
    OP_BS_NZC  = 4'd1,
    OP_ALU_ALL = 4'd2,
    OP_ALU_NZ  = 4'd3,
    OP_ALU_V   = 4'd4,
    OP_ENTRY   = 4'd5,
    OP_RETURN  = 4'd6,
    OP_BIOSOFF = 4'd7,
    OP_CLEAR   = 4'd8,
    OP_LOAD    = 4'd9
  } op_e;

  nzcvm_t           flags_q, flags_d;
  logic             is_bios_q, is_bios_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  nzcvm_t           stack_q [DEPTH];

  logic             full;
  logic             empty;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign push_idx = IDX_W'(level_q);
  assign pop_idx  = IDX_W'(level_q - LVL_W'(1));

  // Next-state decode: one operation per enabled cycle
  always_comb begin
    flags_d   = flags_q;
    is_bios_d = is_bios_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;

    if (bus.enable) begin
      case (bus.update_mode)
        OP_BS_NZC: begin
          flags_d.n = bus.bs_negative;
          flags_d.z = bus.bs_zero;
          flags_d.c = bus.bs_carry;
        end
        OP_ALU_ALL: begin
          flags_d.n = bus.alu_negative;
          flags_d.z = bus.alu_zero;
          flags_d.c = bus.alu_carry;
          flags_d.v = bus.alu_overflow;
        end
        OP_ALU_NZ: begin
          flags_d.n = bus.alu_negative;
          flags_d.z = bus.alu_zero;
        end
        OP_ALU_V: begin
          flags_d.v = bus.alu_overflow;
        end
        OP_ENTRY: begin
          // Mode drops to 0 even when the save is lost to overflow
          flags_d.m = 1'b0;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            level_d = level_q + LVL_W'(1);
          end
        end
        OP_RETURN: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            flags_d = stack_q[pop_idx];
            level_d = level_q - LVL_W'(1);
          end
        end
        OP_BIOSOFF: begin
          is_bios_d = 1'b0;
          flags_d.m = 1'b1;
        end
        OP_CLEAR: begin
          flags_d.n = 1'b0;
          flags_d.z = 1'b0;
          flags_d.c = 1'b0;
          flags_d.v = 1'b0;
        end
        OP_LOAD: begin
          flags_d = nzcvm_t'(bus.wr_data);
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural state; synchronous reset wins over any operation
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q   <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, m: RESET_MODE};
      is_bios_q <= 1'b1;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      is_bios_q <= is_bios_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Save-stack storage carries no reset; contents above level are don't-care
  always_ff @(posedge clock) begin
    if (push_en && !reset) begin
      stack_q[push_idx] <= flags_q;
    end
  end

  assign bus.negative_flag   = flags_q.n;
  assign bus.zero_flag       = flags_q.z;
  assign bus.carry_flag      = flags_q.c;
  assign bus.overflow_flag   = flags_q.v;
  assign bus.mode_flag       = flags_q.m;
  assign bus.is_bios         = is_bios_q;
  assign bus.stack_level     = level_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_spec_reg_stack.sv
// Directed-vector bench for spec_reg_stack: stimulus queues hand-computed
// post-edge state, an independent monitor compares it one cycle later.
module tb_spec_reg_stack;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  logic clock;
  logic reset;
  int   applied;
  int   miscompares;
  sb_t  sb_q [$];

  spec_reg_stack_if #(.DEPTH(DEPTH)) sif ();

  spec_reg_stack #(.DEPTH(DEPTH), .RESET_MODE(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] observed();
    return {sif.negative_flag, sif.zero_flag, sif.carry_flag, sif.overflow_flag,
            sif.mode_flag, sif.is_bios, sif.stack_level, sif.stack_overflow,
            sif.stack_underflow};
  endfunction

  // Monitor: registered outputs are sampled 1 time unit after each posedge
  initial begin
    sb_t e;
    logic [10:0] act;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = observed();
        applied++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got NZCVM=%b bios=%b lvl=%0d ovf=%b unf=%b, want NZCVM=%b bios=%b lvl=%0d ovf=%b unf=%b",
                   e.name, act[10:6], act[5], act[4:2], act[1], act[0],
                   e.exp[10:6], e.exp[5], e.exp[4:2], e.exp[1], e.exp[0]);
        end
      end
    end
  end

  // Drive one cycle of stimulus and queue the state expected after the edge
  task automatic step(input string name, input logic rst, input logic en,
                      input logic [3:0] mode, input logic [3:0] alu_nzcv,
                      input logic [2:0] bs_nzc, input logic [4:0] wr,
                      input logic [4:0] e_f, input logic e_bios,
                      input logic [2:0] e_lvl, input logic e_ovf, input logic e_unf);
    sb_t e;
    @(negedge clock);
    reset            = rst;
    sif.enable       = en;
    sif.update_mode  = mode;
    sif.alu_negative = alu_nzcv[3];
    sif.alu_zero     = alu_nzcv[2];
    sif.alu_carry    = alu_nzcv[1];
    sif.alu_overflow = alu_nzcv[0];
    sif.bs_negative  = bs_nzc[2];
    sif.bs_zero      = bs_nzc[1];
    sif.bs_carry     = bs_nzc[0];
    sif.wr_data      = wr;
    e.name = name;
    e.exp  = {e_f, e_bios, e_lvl, e_ovf, e_unf};
    sb_q.push_back(e);
  endtask

  initial begin
    int budget;
    applied     = 0;
    miscompares = 0;
    reset       = 1'b1;
    sif.enable  = 1'b0;
    sif.update_mode = 4'd0;
    {sif.alu_negative, sif.alu_zero, sif.alu_carry, sif.alu_overflow} = 4'b0;
    {sif.bs_negative, sif.bs_zero, sif.bs_carry} = 3'b0;
    sif.wr_data = 5'b0;

    // reset state, then enable low blocks an ALU update
    step("reset",        1, 0, 4'd0, 4'b0000, 3'b000, 5'b00000, 5'b00000, 1, 3'd0, 0, 0);
    step("en_low_hold",  0, 0, 4'd2, 4'b1111, 3'b111, 5'b11111, 5'b00000, 1, 3'd0, 0, 0);
    // flag update paths
    step("alu_nzcv",     0, 1, 4'd2, 4'b1011, 3'b111, 5'b00000, 5'b10110, 1, 3'd0, 0, 0);
    step("bs_nzc",       0, 1, 4'd1, 4'b0000, 3'b010, 5'b00000, 5'b01010, 1, 3'd0, 0, 0);
    step("alu_v_only",   0, 1, 4'd4, 4'b1110, 3'b101, 5'b00000, 5'b01000, 1, 3'd0, 0, 0);
    step("alu_nz_only",  0, 1, 4'd3, 4'b1111, 3'b000, 5'b00000, 5'b11000, 1, 3'd0, 0, 0);
    step("reserved_10",  0, 1, 4'd10, 4'b0000, 3'b000, 5'b11111, 5'b11000, 1, 3'd0, 0, 0);
    step("reserved_15",  0, 1, 4'd15, 4'b0000, 3'b000, 5'b11111, 5'b11000, 1, 3'd0, 0, 0);
    step("clear_nzcv",   0, 1, 4'd8, 4'b1111, 3'b111, 5'b11111, 5'b00000, 1, 3'd0, 0, 0);
    // single save / restore round trip
    step("load_10101",   0, 1, 4'd9, 4'b0000, 3'b000, 5'b10101, 5'b10101, 1, 3'd0, 0, 0);
    step("entry_1",      0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b10100, 1, 3'd1, 0, 0);
    step("load_zero",    0, 1, 4'd9, 4'b0000, 3'b000, 5'b00000, 5'b00000, 1, 3'd1, 0, 0);
    step("return_1",     0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b10101, 1, 3'd0, 0, 0);
    // fill to DEPTH, overflow, then unwind in LIFO order
    step("load_a",       0, 1, 4'd9, 4'b0000, 3'b000, 5'b00011, 5'b00011, 1, 3'd0, 0, 0);
    step("push_a",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00010, 1, 3'd1, 0, 0);
    step("load_b",       0, 1, 4'd9, 4'b0000, 3'b000, 5'b00101, 5'b00101, 1, 3'd1, 0, 0);
    step("push_b",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00100, 1, 3'd2, 0, 0);
    step("load_c",       0, 1, 4'd9, 4'b0000, 3'b000, 5'b01001, 5'b01001, 1, 3'd2, 0, 0);
    step("push_c",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b01000, 1, 3'd3, 0, 0);
    step("load_d",       0, 1, 4'd9, 4'b0000, 3'b000, 5'b10001, 5'b10001, 1, 3'd3, 0, 0);
    step("push_d",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b10000, 1, 3'd4, 0, 0);
    step("load_e",       0, 1, 4'd9, 4'b0000, 3'b000, 5'b11111, 5'b11111, 1, 3'd4, 0, 0);
    step("push_full",    0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b11110, 1, 3'd4, 1, 0);
    step("pop_d",        0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b10001, 1, 3'd3, 1, 0);
    step("pop_c",        0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b01001, 1, 3'd2, 1, 0);
    step("pop_b",        0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b00101, 1, 3'd1, 1, 0);
    step("pop_a",        0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b00011, 1, 3'd0, 1, 0);
    // underflow, BIOS off, sticky errors do not block later ops
    step("pop_empty",    0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b00011, 1, 3'd0, 1, 1);
    step("load_11000",   0, 1, 4'd9, 4'b0000, 3'b000, 5'b11000, 5'b11000, 1, 3'd0, 1, 1);
    step("bios_off",     0, 1, 4'd7, 4'b0000, 3'b000, 5'b00000, 5'b11001, 0, 3'd0, 1, 1);
    step("en_low_load",  0, 0, 4'd9, 4'b0000, 3'b000, 5'b00000, 5'b11001, 0, 3'd0, 1, 1);
    step("push_after",   0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b11000, 0, 3'd1, 1, 1);
    step("pop_after",    0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b11001, 0, 3'd0, 1, 1);
    step("reset_clears", 1, 0, 4'd0, 4'b0000, 3'b000, 5'b00000, 5'b00000, 1, 3'd0, 0, 0);
    // reset beats a same-cycle entry at level 3
    step("load_00111",   0, 1, 4'd9, 4'b0000, 3'b000, 5'b00111, 5'b00111, 1, 3'd0, 0, 0);
    step("push_1",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00110, 1, 3'd1, 0, 0);
    step("push_2",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00110, 1, 3'd2, 0, 0);
    step("push_3",       0, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00110, 1, 3'd3, 0, 0);
    step("reset_w_push", 1, 1, 4'd5, 4'b0000, 3'b000, 5'b00000, 5'b00000, 1, 3'd0, 0, 0);
    step("pop_post_rst", 0, 1, 4'd6, 4'b0000, 3'b000, 5'b00000, 5'b00000, 1, 3'd0, 0, 1);

    @(negedge clock);
    sif.enable = 1'b0;
    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
